// File: rtl/onchip_ram_pipelined.sv
// Single-port on-chip RAM with byte enables, optional zero-fill after reset,
// and a one- or two-stage registered read pipeline frozen by a global clock enable.
module onchip_ram_pipelined #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 15,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [ADDR_WIDTH-1:0]     address,
  input  logic [DATA_WIDTH/8-1:0]   byteenable,
  input  logic                      chipselect,
  input  logic                      read,
  input  logic                      write,
  input  logic [DATA_WIDTH-1:0]     writedata,
  input  logic                      clken,
  output logic [DATA_WIDTH-1:0]     readdata,
  output logic                      readdatavalid,
  output logic                      waitrequest,
  output logic                      init_done
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int DEPTH     = 1 << ADDR_WIDTH;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_clearCount;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic                    r_s1Valid;
  logic [DATA_WIDTH-1:0]   r_s1Data;
  logic                    r_outValid;

  logic                    w_wrAccept;
  logic                    w_rdAccept;
  logic                    w_nextValid;
  logic [DATA_WIDTH-1:0]   w_nextData;
  logic [DATA_WIDTH-1:0]   w_memWord;

  assign waitrequest   = (r_state == ST_CLEAR) | ~clken;
  assign init_done     = (r_state == ST_READY);
  assign w_wrAccept    = chipselect & write & ~waitrequest;
  assign w_rdAccept    = chipselect & read & ~write & ~waitrequest;
  assign w_memWord     = r_mem[address];
  assign w_nextValid   = (READ_LATENCY == 2) ? r_s1Valid : w_rdAccept;
  assign w_nextData    = (READ_LATENCY == 2) ? r_s1Data  : w_memWord;
  // A registered valid stays parked while clken is low and shows on the next enabled cycle.
  assign readdatavalid = r_outValid & clken;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      r_clearCount <= '0;
    end else if (clken && r_state == ST_CLEAR) begin
      r_clearCount <= r_clearCount + 1'b1;
      if (r_clearCount == '1) begin
        r_state <= ST_READY;
      end
    end
  end

  // The array itself has no reset so its contents survive reset when clearing is disabled.
  always_ff @(posedge clk) begin
    if (reset_n && clken) begin
      if (r_state == ST_CLEAR) begin
        r_mem[r_clearCount] <= '0;
      end else if (w_wrAccept) begin
        for (int b = 0; b < NUM_BYTES; b++) begin
          if (byteenable[b]) begin
            r_mem[address][b*8 +: 8] <= writedata[b*8 +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1Valid  <= 1'b0;
      r_s1Data   <= '0;
      r_outValid <= 1'b0;
      readdata   <= '0;
    end else if (clken) begin
      r_s1Valid  <= w_rdAccept;
      if (w_rdAccept) begin
        r_s1Data <= w_memWord;
      end
      r_outValid <= w_nextValid;
      if (w_nextValid) begin
        readdata <= w_nextData;
      end
    end
  end

endmodule

// File: tb/tb_onchip_ram_pipelined.sv
// Drives two RAM instances (read latency 1 and 2) with identical directed traffic and
// checks both against a queue-based memory model every cycle plus literal expectations.
module tb_onchip_ram_pipelined;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        chipselect;
  logic        read;
  logic        write;
  logic        clken;
  logic [3:0]  address;
  logic [3:0]  byteenable;
  logic [31:0] writedata;

  logic [31:0] readdata1, readdata2;
  logic        readdatavalid1, readdatavalid2;
  logic        waitrequest1, waitrequest2;
  logic        initDone1, initDone2;

  always #5 clk = ~clk;

  onchip_ram_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata), .clken(clken),
    .readdata(readdata1), .readdatavalid(readdatavalid1), .waitrequest(waitrequest1), .init_done(initDone1)
  );

  onchip_ram_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata), .clken(clken),
    .readdata(readdata2), .readdatavalid(readdatavalid2), .waitrequest(waitrequest2), .init_done(initDone2)
  );

  typedef struct { logic [31:0] data; int due; } pend_t;
  typedef struct { int cyc; logic [31:0] data; } obs_t;

  int          errors = 0;
  int          checks = 0;
  int          cycleCount = 0;
  pend_t       pend1[$];
  pend_t       pend2[$];
  obs_t        obs1[$];
  obs_t        obs2[$];
  logic [31:0] modelMem [DEPTH];
  bit          modelActive = 1'b0;
  bit          clearing = 1'b0;
  int          clearIdx = 0;
  int          hiEdges = 0;
  logic [31:0] expData1 = '0;
  logic [31:0] expData2 = '0;
  logic [31:0] rdWord;
  bit          rdOk, wrOk, expValid1, expValid2;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycleCount);
    end
  endtask

  // Model: a read accepted on enabled edge n becomes visible once n+LATENCY-1 enabled edges have passed.
  always @(posedge clk) begin
    cycleCount++;
    if (reset_n === 1'b0) begin
      modelActive = 1'b1;
      clearing    = 1'b1;
      clearIdx    = 0;
      hiEdges     = 0;
      pend1.delete();
      pend2.delete();
      expData1    = '0;
      expData2    = '0;
    end else if (modelActive && clken === 1'b1) begin
      hiEdges++;
      rdOk   = !clearing && chipselect && read && !write;
      wrOk   = !clearing && chipselect && write;
      rdWord = modelMem[address];
      if (clearing) begin
        modelMem[clearIdx] = '0;
        if (clearIdx == DEPTH - 1) clearing = 1'b0;
        clearIdx++;
      end else if (wrOk) begin
        for (int b = 0; b < 4; b++)
          if (byteenable[b]) modelMem[address][b*8 +: 8] = writedata[b*8 +: 8];
      end
      while (pend1.size() > 0 && pend1[0].due < hiEdges) void'(pend1.pop_front());
      while (pend2.size() > 0 && pend2[0].due < hiEdges) void'(pend2.pop_front());
      if (rdOk) begin
        pend1.push_back('{rdWord, hiEdges});
        pend2.push_back('{rdWord, hiEdges + 1});
      end
      if (pend1.size() > 0 && pend1[0].due == hiEdges) expData1 = pend1[0].data;
      if (pend2.size() > 0 && pend2[0].due == hiEdges) expData2 = pend2[0].data;
    end
  end

  always @(negedge clk) begin
    if (modelActive) begin
      expValid1 = (pend1.size() > 0) && (pend1[0].due == hiEdges) && (clken === 1'b1);
      expValid2 = (pend2.size() > 0) && (pend2[0].due == hiEdges) && (clken === 1'b1);
      checkOutput("waitrequest1", 32'(waitrequest1), 32'(clearing || clken !== 1'b1));
      checkOutput("waitrequest2", 32'(waitrequest2), 32'(clearing || clken !== 1'b1));
      checkOutput("init_done1", 32'(initDone1), 32'(!clearing));
      checkOutput("init_done2", 32'(initDone2), 32'(!clearing));
      checkOutput("readdatavalid1", 32'(readdatavalid1), 32'(expValid1));
      checkOutput("readdatavalid2", 32'(readdatavalid2), 32'(expValid2));
      checkOutput("readdata1", readdata1, expData1);
      checkOutput("readdata2", readdata2, expData2);
      if (readdatavalid1 === 1'b1) obs1.push_back('{cycleCount, readdata1});
      if (readdatavalid2 === 1'b1) obs2.push_back('{cycleCount, readdata2});
    end
  end

  task automatic applyStimulus(input logic cs, input logic rd, input logic wr, input logic [3:0] addr,
                               input logic [3:0] be, input logic [31:0] wd, input logic ce);
    @(posedge clk);
    #1;
    chipselect = cs;
    read       = rd;
    write      = wr;
    address    = addr;
    byteenable = be;
    writedata  = wd;
    clken      = ce;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b1);
  endtask

  function automatic obs_t pick(input int which, input int i);
    obs_t none;
    none = '{-1, 32'hDEADBEEF};
    if (which == 1) return (i < obs1.size()) ? obs1[i] : none;
    return (i < obs2.size()) ? obs2[i] : none;
  endfunction

  task automatic countClear(input bit withTraffic);
    int waitHigh;
    int initLow;
    waitHigh = 0;
    initLow  = 0;
    for (int i = 1; i <= 17; i++) begin
      #1;
      if (waitrequest1 === 1'b1) waitHigh++;
      if (initDone1 === 1'b0) initLow++;
      if (i == 16) checkOutput("clear_init_c16", 32'(initDone1), 32'd0);
      if (i == 17) checkOutput("clear_init_c17", 32'(initDone1), 32'd1);
      if (i < 16 && withTraffic) begin
        if (i % 2 == 0) applyStimulus(1'b1, 1'b0, 1'b1, 4'd0, 4'hF, 32'hFFFF_FFFF, 1'b1);
        else            applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 4'hF, 32'd0, 1'b1);
      end else if (i < 17) begin
        idle(1);
      end
    end
    checkOutput("clear_wait_cycles", 32'(waitHigh), 32'd16);
    checkOutput("clear_init_low_cycles", 32'(initLow), 32'd16);
  endtask

  int c;

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    address    = '0;
    byteenable = '0;
    writedata  = '0;
    clken      = 1'b1;

    idle(2);
    reset_n = 1'b1;
    countClear(1'b0);

    obs1.delete();
    obs2.delete();
    for (int a = 0; a < 16; a++) applyStimulus(1'b1, 1'b1, 1'b0, 4'(a), 4'hF, 32'd0, 1'b1);
    idle(4);
    checkOutput("zero_reads_count1", 32'(obs1.size()), 32'd16);
    checkOutput("zero_reads_count2", 32'(obs2.size()), 32'd16);
    checkOutput("zero_read_last", pick(2, 15).data, 32'd0);

    applyStimulus(1'b1, 1'b0, 1'b1, 4'd3, 4'hF, 32'hAABB_CCDD, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd3, 4'b0101, 32'h1122_3344, 1'b1);
    obs1.delete();
    obs2.delete();
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd3, 4'hF, 32'd0, 1'b1);
    idle(4);
    checkOutput("byteenable_merge1", pick(1, 0).data, 32'hAA22_CC44);
    checkOutput("byteenable_merge2", pick(2, 0).data, 32'hAA22_CC44);

    for (int a = 0; a < 3; a++) applyStimulus(1'b1, 1'b0, 1'b1, 4'(a), 4'hF, 32'h100 + 32'(a), 1'b1);
    obs1.delete();
    obs2.delete();
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 4'hF, 32'd0, 1'b1);
    c = cycleCount;
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd1, 4'hF, 32'd0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd2, 4'hF, 32'd0, 1'b1);
    idle(5);
    checkOutput("lat2_count", 32'(obs2.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      checkOutput("lat2_cycle", 32'(pick(2, i).cyc), 32'(c + 2 + i));
      checkOutput("lat2_data", pick(2, i).data, 32'h100 + 32'(i));
    end
    checkOutput("lat1_cycle", 32'(pick(1, 0).cyc), 32'(c + 1));

    applyStimulus(1'b1, 1'b0, 1'b1, 4'd7, 4'hF, 32'h5A5A_0007, 1'b1);
    obs1.delete();
    obs2.delete();
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd7, 4'hF, 32'd0, 1'b1);
    c = cycleCount;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b0);
    idle(4);
    checkOutput("clken_stall_cycle1", 32'(pick(1, 0).cyc), 32'(c + 4));
    checkOutput("clken_stall_cycle2", 32'(pick(2, 0).cyc), 32'(c + 5));
    checkOutput("clken_stall_data2", pick(2, 0).data, 32'h5A5A_0007);

    obs1.delete();
    obs2.delete();
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd5, 4'hF, 32'hCAFE_0005, 1'b1);
    idle(4);
    checkOutput("rdwr_no_valid1", 32'(obs1.size()), 32'd0);
    checkOutput("rdwr_no_valid2", 32'(obs2.size()), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd5, 4'hF, 32'd0, 1'b1);
    idle(4);
    checkOutput("rdwr_later_read1", pick(1, 0).data, 32'hCAFE_0005);
    checkOutput("rdwr_later_read2", pick(2, 0).data, 32'hCAFE_0005);

    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    idle(7);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    obs1.delete();
    obs2.delete();
    countClear(1'b1);
    checkOutput("clear_ignores_reads", 32'(obs1.size()), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 4'hF, 32'd0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd3, 4'hF, 32'd0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd7, 4'hF, 32'd0, 1'b1);
    idle(4);
    checkOutput("reclear_addr0", pick(2, 0).data, 32'd0);
    checkOutput("reclear_addr3", pick(2, 1).data, 32'd0);
    checkOutput("reclear_addr7", pick(1, 2).data, 32'd0);
    checkOutput("reclear_count", 32'(obs2.size()), 32'd3);

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
